// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the mul/div scheduler and its tag FIFO.
package muldiv_pkg;

  localparam logic UNIT_MUL = 1'b0;
  localparam logic UNIT_DIV = 1'b1;

  // One-hot op bit positions
  localparam int MUL_W  = 0;
  localparam int MUL_H  = 1;
  localparam int MUL_HU = 2;
  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  typedef struct packed {
    logic unit;
    logic sel_hi;  // mul: upper product half; div: remainder
    logic kill;
  } tag_t;

  function automatic logic sel_decode(input logic unit, input logic [2:0] mop,
                                      input logic [3:0] dop);
    return (unit == UNIT_DIV) ? (dop[MOD_W] | dop[MOD_WU]) : (mop[MUL_H] | mop[MUL_HU]);
  endfunction

endpackage

// File: rtl/muldiv_tag_fifo.sv
// Circular program-order tag FIFO; kill_all marks every live entry as discarded.
module muldiv_tag_fifo
  import muldiv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  tag_t          push_tag,
  input  logic          pop,
  input  logic          kill_all,
  output tag_t          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  tag_t          mem_q [DEPTH];
  tag_t          mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] off;

  always_comb begin
    mem_d = mem_q;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // distance from head decides whether slot i currently holds a live entry
      off = AW'(i) - rd_q;
      if (kill_all && ({1'b0, off} < count_q)) mem_d[i].kill = 1'b1;
    end
    if (push) mem_d[wr_q] = push_tag;
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/muldiv_sched.sv
// In-order issue/retire scheduler between EX/MEM and the shared mul/div units.
// Define MULDIV_SCHED_RESP_REG_EN to add a one-entry output register toward MEM.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_unit,
  input  logic [2:0]  req_mul_op,
  input  logic [3:0]  req_div_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        to_mul_req_valid,
  input  logic        from_mul_req_ready,
  output logic [2:0]  mul_op,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic        to_mul_resp_ready,
  input  logic        from_mul_resp_valid,
  input  logic [63:0] mul_result,
  output logic        to_div_req_valid,
  input  logic        from_div_req_ready,
  output logic [3:0]  div_op,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        to_div_resp_ready,
  input  logic        from_div_resp_valid,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  tag_t          head, push_tag;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic          head_valid, head_kill, head_ready, unit_rvalid, out_ready, deliver;
  logic [31:0]   sel_data;

  muldiv_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (push_tag),
    .pop      (pop),
    .kill_all (flush),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign mul_op       = req_mul_op;
  assign mul_x        = req_src1;
  assign mul_y        = req_src2;
  assign div_op       = req_div_op;
  assign div_dividend = req_src1;
  assign div_divisor  = req_src2;
  assign busy         = (count != '0);

  always_comb begin
    // Issue side never looks at unit ready when raising valid
    to_mul_req_valid = req_valid & (req_unit == UNIT_MUL) & ~full & ~flush;
    to_div_req_valid = req_valid & (req_unit == UNIT_DIV) & ~full & ~flush;
    req_ready        = (to_mul_req_valid & from_mul_req_ready) |
                       (to_div_req_valid & from_div_req_ready);
    push             = req_ready;
    push_tag         = '{unit: req_unit,
                         sel_hi: sel_decode(req_unit, req_mul_op, req_div_op),
                         kill: 1'b0};

    // A flush discards even the response popping in the same cycle
    head_valid  = ~empty;
    head_kill   = head.kill | flush;
    unit_rvalid = (head.unit == UNIT_DIV) ? from_div_resp_valid : from_mul_resp_valid;
    if (head.unit == UNIT_DIV) sel_data = head.sel_hi ? div_remainder : div_quotient;
    else                       sel_data = head.sel_hi ? mul_result[63:32] : mul_result[31:0];
  end

`ifdef MULDIV_SCHED_RESP_REG_EN
  logic        out_vld_q, out_vld_d;
  logic [31:0] out_data_q, out_data_d;

  assign out_ready = ~out_vld_q | resp_ready;

  always_comb begin
    out_vld_d  = out_vld_q & ~resp_ready;
    out_data_d = out_data_q;
    if (deliver) begin
      out_vld_d  = 1'b1;
      out_data_d = sel_data;
    end
    if (flush) out_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign resp_valid = out_vld_q;
  assign resp_data  = out_vld_q ? out_data_q : '0;
`else
  assign out_ready  = resp_ready;
  assign resp_valid = head_valid & ~head_kill & unit_rvalid;
  assign resp_data  = resp_valid ? sel_data : '0;
`endif

  always_comb begin
    head_ready        = head_valid & (head_kill | out_ready);
    to_mul_resp_ready = head_ready & (head.unit == UNIT_MUL);
    to_div_resp_ready = head_ready & (head.unit == UNIT_DIV);
    pop               = head_ready & unit_rvalid;
    deliver           = pop & ~head_kill;
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: vector table, corner sequences and a random run.
module tb_muldiv_sched;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst;
  logic flush, req_valid, req_ready, req_unit;
  logic [2:0] req_mul_op;
  logic [3:0] req_div_op;
  logic [31:0] req_src1, req_src2;
  logic to_mul_req_valid, from_mul_req_ready, to_mul_resp_ready, from_mul_resp_valid;
  logic [2:0] mul_op;
  logic [31:0] mul_x, mul_y;
  logic [63:0] mul_result;
  logic to_div_req_valid, from_div_req_ready, to_div_resp_ready, from_div_resp_valid;
  logic [3:0] div_op;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic resp_valid, resp_ready, busy;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  muldiv_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
    .req_mul_op(req_mul_op), .req_div_op(req_div_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .to_mul_req_valid(to_mul_req_valid), .from_mul_req_ready(from_mul_req_ready),
    .mul_op(mul_op), .mul_x(mul_x), .mul_y(mul_y),
    .to_mul_resp_ready(to_mul_resp_ready), .from_mul_resp_valid(from_mul_resp_valid),
    .mul_result(mul_result),
    .to_div_req_valid(to_div_req_valid), .from_div_req_ready(from_div_req_ready),
    .div_op(div_op), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .to_div_resp_ready(to_div_resp_ready), .from_div_resp_valid(from_div_resp_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy)
  );

  typedef struct { bit unit; logic [31:0] val; bit killed; } ref_t;
  typedef struct { logic [63:0] prod; logic [31:0] quo; logic [31:0] rem; int rdy; } ures_t;
  typedef struct { bit unit; logic [2:0] mop; logic [3:0] dop;
                   logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;

  ref_t  rq[$];
  ures_t mq[$], dq[$];
  logic [31:0] got[$];
  int checks = 0, errors = 0, cyc = 0;
  int mul_lat = 1, div_lat = 1;
  bit mul_rq_en = 1, div_rq_en = 1, mul_rs_en = 1, div_rs_en = 1;
  bit s_req_fire, s_mul_fire, s_div_fire, s_mul_rr, s_div_rr, s_mrv;
  bit s_resp_valid, s_mul_rfire, s_div_rfire, s_out_fire;
  logic [31:0] s_resp_data;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Architectural result of an op, straight from the ISA definitions
  function automatic logic [31:0] expect_val(input bit unit, input logic [2:0] mop,
      input logic [3:0] dop, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint sp;
    longint unsigned up;
    sa = a; sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'b0, a} * {32'b0, b};
    if (!unit) begin
      if (mop[0]) return sp[31:0];
      if (mop[1]) return sp[63:32];
      return up[63:32];
    end
    if (dop[0]) return 32'(sa / sb);
    if (dop[1]) return 32'(sa % sb);
    if (dop[2]) return a / b;
    return a % b;
  endfunction

  task automatic drive_units();
    from_mul_req_ready = mul_rq_en;
    from_div_req_ready = div_rq_en;
    from_mul_resp_valid = 1'b0; mul_result = '0;
    from_div_resp_valid = 1'b0; div_quotient = '0; div_remainder = '0;
    if (mq.size() > 0) begin
      from_mul_resp_valid = mul_rs_en && (mq[0].rdy <= cyc);
      mul_result = mq[0].prod;
    end
    if (dq.size() > 0) begin
      from_div_resp_valid = div_rs_en && (dq[0].rdy <= cyc);
      div_quotient = dq[0].quo; div_remainder = dq[0].rem;
    end
  endtask

  task automatic cycle();
    bit fe, fu, fk, urv, ev, emq, edq, full_m;
    logic [31:0] ed;
    ures_t u;
    int sa, sb;
    drive_units();
    #1;
    fe = rq.size() > 0;
    fu = fe ? rq[0].unit : 1'b0;
    fk = fe && (rq[0].killed || flush);
    urv = fu ? from_div_resp_valid : from_mul_resp_valid;
    ev = fe && !fk && urv;
    ed = ev ? rq[0].val : 32'h0;
    full_m = rq.size() >= DEPTH;
    emq = req_valid && !req_unit && !full_m && !flush;
    edq = req_valid && req_unit && !full_m && !flush;
    chk("req_valids", {to_mul_req_valid, to_div_req_valid}, {emq, edq});
    chk("req_ready", req_ready, (emq && from_mul_req_ready) || (edq && from_div_req_ready));
    chk("resp_readies", {to_mul_resp_ready, to_div_resp_ready},
        {fe && !fu && (fk || resp_ready), fe && fu && (fk || resp_ready)});
    chk("resp_valid", resp_valid, ev);
    chk("resp_data", resp_data, ed);
    chk("busy", busy, fe);
    chk("payload", {mul_op, mul_x, mul_y, div_op, div_dividend, div_divisor},
        {req_mul_op, req_src1, req_src2, req_div_op, req_src1, req_src2});
    s_mul_fire   = to_mul_req_valid && from_mul_req_ready;
    s_div_fire   = to_div_req_valid && from_div_req_ready;
    s_req_fire   = s_mul_fire || s_div_fire;
    s_mul_rr     = to_mul_resp_ready;
    s_div_rr     = to_div_resp_ready;
    s_mrv        = from_mul_resp_valid;
    s_mul_rfire  = from_mul_resp_valid && to_mul_resp_ready;
    s_div_rfire  = from_div_resp_valid && to_div_resp_ready;
    s_resp_valid = resp_valid;
    s_resp_data  = resp_data;
    s_out_fire   = resp_valid && resp_ready;
    if (s_out_fire) got.push_back(resp_data);
    @(posedge clk);
    cyc++;
    if (s_mul_rfire && mq.size() > 0) void'(mq.pop_front());
    if (s_div_rfire && dq.size() > 0) void'(dq.pop_front());
    if ((s_mul_rfire || s_div_rfire) && rq.size() > 0) void'(rq.pop_front());
    if (flush) foreach (rq[i]) rq[i].killed = 1'b1;
    if (s_mul_fire) begin
      sa = req_src1; sb = req_src2;
      u.prod = req_mul_op[2] ? {32'b0, req_src1} * {32'b0, req_src2}
                             : 64'(longint'(sa) * longint'(sb));
      u.quo = '0; u.rem = '0;
      u.rdy = cyc + mul_lat;
      if (mq.size() > 0 && mq[mq.size()-1].rdy > u.rdy) u.rdy = mq[mq.size()-1].rdy;
      mq.push_back(u);
    end
    if (s_div_fire) begin
      sa = req_src1; sb = req_src2;
      u.prod = '0;
      if (req_div_op[0] || req_div_op[1]) begin
        u.quo = 32'(sa / sb); u.rem = 32'(sa % sb);
      end else begin
        u.quo = req_src1 / req_src2; u.rem = req_src1 % req_src2;
      end
      u.rdy = cyc + div_lat;
      if (dq.size() > 0 && dq[dq.size()-1].rdy > u.rdy) u.rdy = dq[dq.size()-1].rdy;
      dq.push_back(u);
    end
    if (s_req_fire)
      rq.push_back('{unit: req_unit, killed: 1'b0,
                     val: expect_val(req_unit, req_mul_op, req_div_op, req_src1, req_src2)});
    @(negedge clk);
  endtask

  task automatic issue(input bit u, input logic [2:0] mo, input logic [3:0] dv,
                       input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    req_valid = 1'b1; req_unit = u; req_mul_op = mo; req_div_op = dv;
    req_src1 = a; req_src2 = b;
    do begin cycle(); n++; end while (!s_req_fire && n < 20);
    if (!s_req_fire) chk("issue_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_got(input int target);
    int n = 0;
    while (got.size() < target && n < 60) begin cycle(); n++; end
    if (got.size() < target) chk("result_timeout", got.size(), target);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    mul_rq_en = 1; div_rq_en = 1; mul_rs_en = 1; div_rs_en = 1;
    while (rq.size() > 0 && n < 80) begin cycle(); n++; end
    chk("drain_empty", rq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    @(posedge clk);
    mq.delete(); dq.delete(); rq.delete();
    @(negedge clk);
    drive_units();
    #1;
    chk("reset_state", {to_mul_req_valid, to_div_req_valid, req_ready, to_mul_resp_ready,
                        to_div_resp_ready, resp_valid, resp_data, busy}, '0);
    rst = 1'b0;
    resp_ready = 1'b1;
  endtask

  initial begin
    vec_t vt[10];
    int base, bad, early, nv, nf, sz;
    vt[0] = '{0, 3'b001, 4'b0000, 32'd3,        32'd5,        32'd15};
    vt[1] = '{0, 3'b100, 4'b0000, 32'hFFFFFFFF, 32'd2,        32'h1};
    vt[2] = '{0, 3'b010, 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    vt[3] = '{0, 3'b010, 4'b0000, 32'h80000000, 32'd2,        32'hFFFFFFFF};
    vt[4] = '{0, 3'b001, 4'b0000, 32'h10000,    32'h10000,    32'h0};
    vt[5] = '{1, 3'b000, 4'b0001, 32'd7,        32'd2,        32'd3};
    vt[6] = '{1, 3'b000, 4'b0001, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vt[7] = '{1, 3'b000, 4'b0010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vt[8] = '{1, 3'b000, 4'b0100, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC};
    vt[9] = '{1, 3'b000, 4'b1000, 32'hFFFFFFF9, 32'd2,        32'h1};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_unit = 1'b0;
    req_mul_op = '0; req_div_op = '0; req_src1 = '0; req_src2 = '0; resp_ready = 1'b0;
    drive_units();
    repeat (2) @(posedge clk);
    do_reset();

    // Vector table, one op at a time
    foreach (vt[i]) begin
      base = got.size();
      issue(vt[i].unit, vt[i].mop, vt[i].dop, vt[i].a, vt[i].b);
      wait_got(base + 1);
      if (got.size() > base) chk($sformatf("vec%0d", i), got[base], vt[i].exp);
    end

    // Back-to-back mul ops retire in order
    base = got.size();
    issue(0, 3'b001, 4'b0, 32'd3, 32'd5);
    issue(0, 3'b100, 4'b0, 32'hFFFFFFFF, 32'd2);
    wait_got(base + 2);
    if (got.size() >= base + 2) begin
      chk("pair_first", got[base], 32'd15);
      chk("pair_second", got[base+1], 32'h1);
    end

    // Slow divide ahead of a fast multiply
    div_lat = 6; mul_lat = 1; base = got.size(); bad = 0; early = 0;
    issue(1, 3'b0, 4'b0001, 32'd7, 32'd2);
    issue(0, 3'b001, 4'b0, 32'd2, 32'd2);
    for (int n = 0; n < 40 && got.size() < base + 2; n++) begin
      sz = got.size();
      cycle();
      if (sz == base && s_mul_rr) bad++;
      if (sz == base && s_mrv) early++;
    end
    chk("order_hold_mul", bad, 0);
    chk("order_mul_first", early > 0, 1);
    if (got.size() >= base + 2) begin
      chk("order_first", got[base], 32'd3);
      chk("order_second", got[base+1], 32'd4);
    end
    div_lat = 1;

    // Fill the FIFO with responses stalled
    mul_rs_en = 0;
    for (int i = 0; i < DEPTH; i++) issue(0, 3'b001, 4'b0, i, 32'd3);
    req_valid = 1'b1; req_unit = 1'b0; req_mul_op = 3'b001; req_src1 = 32'd9; req_src2 = 32'd9;
    cycle();
    chk("full_block", s_req_fire, 0);
    mul_rs_en = 1;
    cycle();
    chk("full_pop", s_mul_rfire, 1);
    chk("full_no_bypass", s_req_fire, 0);
    mul_rs_en = 0;
    cycle();
    chk("full_accept_after_pop", s_req_fire, 1);
    drain();

    // Flush with three ops outstanding
    mul_rs_en = 0; div_rs_en = 0;
    issue(0, 3'b001, 4'b0, 32'd4, 32'd4);
    issue(1, 3'b0, 4'b0001, 32'd9, 32'd3);
    issue(0, 3'b010, 4'b0, 32'd5, 32'd6);
    flush = 1'b1; cycle(); flush = 1'b0;
    mul_rs_en = 1; div_rs_en = 1; resp_ready = 1'b1; nv = 0; nf = 0;
    for (int n = 0; n < 40 && rq.size() > 0; n++) begin
      cycle();
      nv += int'(s_resp_valid);
      nf += int'(s_mul_rfire) + int'(s_div_rfire);
    end
    chk("flush_no_resp", nv, 0);
    chk("flush_consumed", nf, 3);
    cycle();
    chk("flush_busy_low", busy, 0);
    base = got.size();
    issue(1, 3'b0, 4'b0010, 32'hFFFFFFF9, 32'd2);
    wait_got(base + 1);
    if (got.size() > base) chk("post_flush_mod", got[base], 32'hFFFFFFFF);

    // MEM backpressure for five cycles
    resp_ready = 1'b0; base = got.size();
    issue(0, 3'b001, 4'b0, 32'd6, 32'd7);
    for (int n = 0; n < 10 && !s_mrv; n++) cycle();
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("stall_rr", s_mul_rr, 0);
      chk("stall_valid", s_resp_valid, 1);
      chk("stall_data", s_resp_data, 32'd42);
    end
    resp_ready = 1'b1;
    cycle();
    chk("stall_retire", s_out_fire, 1);
    chk("stall_count", got.size(), base + 1);

    // Reset with two ops in flight
    mul_rs_en = 0;
    issue(0, 3'b001, 4'b0, 32'd1, 32'd1);
    issue(0, 3'b001, 4'b0, 32'd2, 32'd1);
    do_reset();
    mul_rs_en = 1;

    // Random traffic against the reference queue
    for (int n = 0; n < 500; n++) begin
      req_valid  = $urandom_range(0, 1) == 1;
      req_unit   = $urandom_range(0, 1) == 1;
      req_mul_op = 3'(1 << $urandom_range(0, 2));
      req_div_op = 4'(1 << $urandom_range(0, 3));
      req_src1   = $urandom;
      req_src2   = $urandom;
      if (req_src2 == 32'h0 || req_src2 == 32'hFFFFFFFF) req_src2 = 32'd5;
      resp_ready = $urandom_range(0, 3) != 0;
      flush      = $urandom_range(0, 19) == 0;
      mul_rq_en  = $urandom_range(0, 3) != 0;
      div_rq_en  = $urandom_range(0, 3) != 0;
      mul_rs_en  = $urandom_range(0, 3) != 0;
      div_rs_en  = $urandom_range(0, 3) != 0;
      mul_lat    = $urandom_range(1, 3);
      div_lat    = $urandom_range(1, 6);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

In-order issue/retire scheduler that sits between the EX and MEM stages and owns every valid/ready handshake to the shared multiplier and divider units. It accepts one mul/div request per cycle from EX and routes it to the correct unit. A tag FIFO records program order so results are returned to MEM strictly in order, with the correct 32-bit half or quotient/remainder selected. Pipeline flushes are honoured by draining outstanding results without presenting them to MEM.

## Interface
Parameters:
- DEPTH, 4: maximum outstanding ops (tag FIFO entries); power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  cancel all outstanding and in-flight ops
- req_valid  in  1  EX presents a mul/div op
- req_ready  out  1  op accepted this cycle
- req_unit  in  1  0 = multiplier, 1 = divider
- req_mul_op  in  3  one-hot: [0] mul.w, [1] mulh.w, [2] mulh.wu
- req_div_op  in  4  one-hot: [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu
- req_src1, req_src2  in  32  operands
- to_mul_req_valid  out  1, from_mul_req_ready  in  1  multiplier request handshake
- mul_op  out  3, mul_x  out  32, mul_y  out  32  multiplier request payload
- to_mul_resp_ready  out  1, from_mul_resp_valid  in  1  multiplier response handshake
- mul_result  in  64  multiplier product
- to_div_req_valid  out  1, from_div_req_ready  in  1  divider request handshake
- div_op  out  4, div_dividend  out  32, div_divisor  out  32  divider request payload
- to_div_resp_ready  out  1, from_div_resp_valid  in  1  divider response handshake
- div_quotient, div_remainder  in  32  divider results
- resp_valid  out  1, resp_ready  in  1  result handshake toward MEM
- resp_data  out  32  selected result
- busy  out  1  tag FIFO non-empty (used by ID for hazard stall)

## Operation
- Tag entry = {unit, sel_hi, kill}. sel_hi = mul_op[1]|mul_op[2] for mul; rem = div_op[1]|div_op[3] for div.
- Issue: to_X_req_valid = req_valid & (req_unit==X) & !full & !flush. Valid never depends on the unit's ready. req_ready = to_X_req_valid & from_X_req_ready. On a fire, push the tag. Operands and op pass through combinationally.
- Retire: head unit H. to_H_resp_ready = head_valid & (head.kill | resp_ready). The other unit's resp_ready is 0. Pop when from_H_resp_valid & to_H_resp_ready.
- resp_valid = head_valid & !head.kill & from_H_resp_valid.
- resp_data: mul → sel_hi ? mul_result[63:32] : mul_result[31:0]; div → rem ? div_remainder : div_quotient. It is 0 when resp_valid=0.
- Flush: sets kill on every valid entry in the same cycle. Killed entries still wait for their unit response, which is consumed and discarded. No push occurs in a flush cycle. A response popping in the flush cycle is discarded.
- Full: count==DEPTH blocks push; there is no push bypass from a same-cycle pop. Empty: all resp-side readies are 0.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap mod DEPTH.

## Timing
- Reset values: count=0, pointers=0, all kill=0. All valid/ready outputs are 0, resp_data=0, busy=0.
- Issue and retire are combinational through the block: zero added latency. Total latency = unit latency.
- busy is registered; it reflects count after the previous edge.
- rst mid-operation empties the FIFO. Units are reset by the same rst, so no stale responses arrive.
- Order: result N is never presented before result N-1, even if the other unit finishes first.

## Configuration
- MULDIV_SCHED_RESP_REG_EN defined: a one-entry output register sits between retire and MEM.
  - Adds 1 cycle of latency.
  - Unit resp_ready uses "register empty or draining".
  - flush clears the register's valid.
- Not defined: purely combinational retire path as described above.

## Structure
- Package muldiv_pkg holds:
  - UNIT_MUL/UNIT_DIV constants
  - mul/div op one-hot bit positions
  - tag entry struct
  - sel_hi/rem decode function
- Sub-module muldiv_tag_fifo: DEPTH-parameterised circular FIFO with push/pop/count/full/empty and a broadcast kill_all input that sets kill on valid entries.

## Test plan
- mul.w 3×5 then mulh.wu 0xFFFFFFFF×2 → resp_data 15, then 0x00000001, in order.
- div.w 7/2 issued, then mul.w 2×2 issued and the multiplier finishes first → resp sequence 3, then 4. to_mul_resp_ready is held at 0 until the div result retires.
- Issue DEPTH ops with units stalled on response → req_ready=0 on the (DEPTH+1)th op. After one pop, the next op is accepted the following cycle.
- 3 ops outstanding, flush asserted → resp_valid stays 0 while all 3 unit responses are consumed. busy drops after the last one. A new mod.w −7 % 2 afterward returns 0xFFFFFFFF.
- resp_ready=0 for 5 cycles with a result pending → to_X_resp_ready=0 and resp_data stable. Retires on the first cycle resp_ready=1.
- rst asserted with 2 ops outstanding → next cycle busy=0 and all valids=0.
